// File: rtl/sdpb_fifo_ctrl.sv
// sdpb_fifo_ctrl: first-word-fall-through FIFO controller wrapped around a
// 4096x16 simple dual-port block RAM with a 1-cycle registered read.
// Writes go straight to RAM port A; reads are issued on port B ahead of
// demand and land in a 2-entry output buffer whose head drives m_data.
module sdpb_fifo_ctrl #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned AFULL_THRESH = 4032
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W+1:0] count,
  output logic              full,
  output logic              almost_full,
  output logic              ram_cea,
  output logic [ADDR_W-1:0] ram_ada,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_ceb,
  output logic [ADDR_W-1:0] ram_adb,
  output logic              ram_oce,
  output logic              ram_reset,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W:0]   RAM_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W+1:0] AFULL_LVL = (ADDR_W+2)'(AFULL_THRESH);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   RCNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W+1:0] CNT_ONE   = (ADDR_W+2)'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic [ADDR_W+1:0] count_q, count_d;
  logic              rd_pend_q, rd_pend_d;
  logic [1:0]        obuf_cnt_q, obuf_cnt_d;
  logic [DATA_W-1:0] obuf0_q, obuf0_d;
  logic [DATA_W-1:0] obuf1_q, obuf1_d;

  logic       clr;
  logic       accept;
  logic       pop;
  logic       issue;
  logic [2:0] committed;

  assign clr     = reset | flush;
  assign s_ready = (ram_cnt_q < RAM_DEPTH) & ~clr;
  assign accept  = s_valid & s_ready;
  assign m_valid = (obuf_cnt_q != 2'd0);
  assign pop     = m_valid & m_ready;

  // Output slots already owed (buffered + in flight) once this cycle's pop leaves.
  assign committed = {1'b0, obuf_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign issue     = ~clr & (ram_cnt_q != '0) & (committed < 3'd2);

  assign ram_cea     = accept;
  assign ram_ada     = wr_ptr_q;
  assign ram_din     = s_data;
  assign ram_ceb     = issue;
  assign ram_adb     = rd_ptr_q;
  assign ram_oce     = 1'b1;
  assign ram_reset   = clr;
  assign m_data      = obuf0_q;
  assign count       = count_q;
  assign full        = ~s_ready & ~reset;
  assign almost_full = (count_q >= AFULL_LVL);

  // Next-state for pointers, occupancy counters and the output buffer.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    count_d    = count_q;
    rd_pend_d  = issue;
    obuf_cnt_d = obuf_cnt_q;
    obuf0_d    = obuf0_q;
    obuf1_d    = obuf1_q;

    if (accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (issue)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({accept, issue})
      2'b10:   ram_cnt_d = ram_cnt_q + RCNT_ONE;
      2'b01:   ram_cnt_d = ram_cnt_q - RCNT_ONE;
      default: ram_cnt_d = ram_cnt_q;
    endcase

    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Pop shifts the tail into the head first; the captured word then lands
    // in the first free slot, so a same-cycle pop and capture keep order.
    if (pop) begin
      obuf0_d    = obuf1_q;
      obuf_cnt_d = obuf_cnt_q - 2'd1;
    end
    if (rd_pend_q) begin
      if (obuf_cnt_d == 2'd0) obuf0_d = ram_dout;
      else                    obuf1_d = ram_dout;
      obuf_cnt_d = obuf_cnt_d + 2'd1;
    end
  end

  // State registers; reset and flush discard everything, including a read in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      count_q    <= '0;
      rd_pend_q  <= 1'b0;
      obuf_cnt_q <= '0;
      obuf0_q    <= '0;
      obuf1_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      count_q    <= count_d;
      rd_pend_q  <= rd_pend_d;
      obuf_cnt_q <= obuf_cnt_d;
      obuf0_q    <= obuf0_d;
      obuf1_q    <= obuf1_d;
    end
  end

endmodule

// File: tb/tb_sdpb_fifo_ctrl.sv
// Testbench for sdpb_fifo_ctrl with a behavioural 4096x16 registered-read RAM.
module tb_sdpb_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset, flush, s_valid, m_ready;
  logic [15:0] s_data;
  logic        s_ready, m_valid, full, almost_full;
  logic [15:0] m_data;
  logic [13:0] count;
  logic        ram_cea, ram_ceb, ram_oce, ram_reset;
  logic [11:0] ram_ada, ram_adb;
  logic [15:0] ram_din, ram_dout;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sdpb_fifo_ctrl #(.DATA_W(16), .ADDR_W(12), .AFULL_THRESH(4032)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .full(full), .almost_full(almost_full),
    .ram_cea(ram_cea), .ram_ada(ram_ada), .ram_din(ram_din),
    .ram_ceb(ram_ceb), .ram_adb(ram_adb), .ram_oce(ram_oce),
    .ram_reset(ram_reset), .ram_dout(ram_dout)
  );

  // Block RAM model: write port A, registered read port B, output cleared by ram_reset.
  logic [15:0] mem [0:4095];
  always_ff @(posedge clk) begin
    if (ram_cea) mem[ram_ada] <= ram_din;
    if (ram_reset)    ram_dout <= '0;
    else if (ram_ceb) ram_dout <= mem[ram_adb];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic do_reset;
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    next_cycle;
    next_cycle;
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rst, fl, sv;
    logic [15:0] sd;
    logic        mr;
    logic        e_sready, e_full, e_mvalid;
    logic [15:0] e_mdata;
    logic [13:0] e_count;
    logic        e_cea;
    logic [11:0] e_ada;
    logic        e_ceb;
    logic [11:0] e_adb;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  // Global guard so a stuck run still ends.
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst fl sv sd       mr  srdy full mv mdata    cnt cea ada ceb adb
    vt[0]  = '{1'b1,1'b0,1'b1,16'h1111,1'b0, 1'b0,1'b0,1'b0,16'h0000,14'd0,1'b0,12'd0,1'b0,12'd0};
    vt[1]  = '{1'b0,1'b0,1'b1,16'h1234,1'b1, 1'b1,1'b0,1'b0,16'h0000,14'd0,1'b1,12'd0,1'b0,12'd0};
    vt[2]  = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,1'b0,16'h0000,14'd1,1'b0,12'd0,1'b1,12'd0};
    vt[3]  = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,1'b0,16'h0000,14'd1,1'b0,12'd0,1'b0,12'd0};
    vt[4]  = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,1'b1,16'h1234,14'd1,1'b0,12'd0,1'b0,12'd0};
    vt[5]  = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,1'b0,16'h0000,14'd0,1'b0,12'd0,1'b0,12'd0};
    vt[6]  = '{1'b0,1'b0,1'b1,16'hA001,1'b0, 1'b1,1'b0,1'b0,16'h0000,14'd0,1'b1,12'd1,1'b0,12'd0};
    vt[7]  = '{1'b0,1'b0,1'b1,16'hA002,1'b0, 1'b1,1'b0,1'b0,16'h0000,14'd1,1'b1,12'd2,1'b1,12'd1};
    vt[8]  = '{1'b0,1'b0,1'b1,16'hA003,1'b0, 1'b1,1'b0,1'b0,16'h0000,14'd2,1'b1,12'd3,1'b1,12'd2};
    vt[9]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b1,16'hA001,14'd3,1'b0,12'd0,1'b0,12'd0};
    vt[10] = '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b1,16'hA001,14'd3,1'b0,12'd0,1'b0,12'd0};
    vt[11] = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,1'b1,16'hA001,14'd3,1'b0,12'd0,1'b1,12'd3};
    vt[12] = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,1'b1,16'hA002,14'd2,1'b0,12'd0,1'b0,12'd0};
    vt[13] = '{1'b0,1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,1'b1,16'hA003,14'd1,1'b0,12'd0,1'b0,12'd0};
    vt[14] = '{1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0,16'h0000,14'd0,1'b0,12'd0,1'b0,12'd0};

    do_reset;
    reset = 1'b1;

    // ---------------- table-driven single-word latency and small burst
    for (int i = 0; i < NV; i++) begin
      reset = vt[i].rst; flush = vt[i].fl; s_valid = vt[i].sv;
      s_data = vt[i].sd; m_ready = vt[i].mr;
      settle;
      chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(vt[i].e_sready));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vt[i].e_full));
      chk($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(vt[i].e_mvalid));
      if (vt[i].e_mvalid) chk($sformatf("v%0d_m_data", i), 32'(m_data), 32'(vt[i].e_mdata));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].e_count));
      chk($sformatf("v%0d_almost_full", i), 32'(almost_full), 32'd0);
      chk($sformatf("v%0d_ram_cea", i), 32'(ram_cea), 32'(vt[i].e_cea));
      if (vt[i].e_cea) chk($sformatf("v%0d_ram_ada", i), 32'(ram_ada), 32'(vt[i].e_ada));
      chk($sformatf("v%0d_ram_ceb", i), 32'(ram_ceb), 32'(vt[i].e_ceb));
      if (vt[i].e_ceb) chk($sformatf("v%0d_ram_adb", i), 32'(ram_adb), 32'(vt[i].e_adb));
      chk($sformatf("v%0d_ram_reset", i), 32'(ram_reset), 32'(vt[i].rst | vt[i].fl));
      chk($sformatf("v%0d_ram_oce", i), 32'(ram_oce), 32'd1);
      next_cycle;
    end

    // ---------------- fill to capacity with a stalled consumer, then drain
    begin
      int acc = 0;
      int afull_first = -1;
      int trk_err = 0;
      int got = 0;
      int derr = 0;
      do_reset;
      s_valid = 1'b1;
      for (int cyc = 0; cyc < 4300 && acc < 4098; cyc++) begin
        s_data = acc[15:0];
        settle;
        if (32'(count) != 32'(acc)) trk_err++;
        if (almost_full && afull_first < 0) afull_first = int'(count);
        if (s_ready) acc++;
        next_cycle;
      end
      s_data = 16'hFFFF;
      settle;
      chk("fill_accepted", 32'(acc), 32'd4098);
      chk("fill_count_track", 32'(trk_err), 32'd0);
      chk("fill_afull_first", 32'(afull_first), 32'd4032);
      chk("fill_count", 32'(count), 32'd4098);
      chk("fill_s_ready", 32'(s_ready), 32'd0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_almost_full", 32'(almost_full), 32'd1);
      chk("fill_blocked_cea", 32'(ram_cea), 32'd0);
      next_cycle;
      settle;
      chk("fill_count_hold", 32'(count), 32'd4098);

      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int cyc = 0; cyc < 4400 && got < 4098; cyc++) begin
        settle;
        if (m_valid) begin
          if (m_data !== got[15:0]) derr++;
          got++;
        end
        next_cycle;
      end
      settle;
      chk("drain_words", 32'(got), 32'd4098);
      chk("drain_order_errors", 32'(derr), 32'd0);
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_m_valid", 32'(m_valid), 32'd0);
      chk("drain_full", 32'(full), 32'd0);
    end

    // ---------------- sustained streaming across several pointer wraps
    begin
      int nacc = 0;
      int nrecv = 0;
      int serr = 0;
      int maxcnt = 0;
      int first_pop = -1;
      int last_pop = 0;
      do_reset;
      m_ready = 1'b1;
      for (int cyc = 0; cyc < 20200 && nrecv < 20000; cyc++) begin
        s_valid = (nacc < 20000);
        s_data  = nacc[15:0];
        settle;
        if (s_valid && s_ready) nacc++;
        if (m_valid) begin
          if (m_data !== nrecv[15:0]) serr++;
          nrecv++;
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
        end
        if (int'(count) > maxcnt) maxcnt = int'(count);
        next_cycle;
      end
      s_valid = 1'b0;
      chk("stream_words", 32'(nrecv), 32'd20000);
      chk("stream_order_errors", 32'(serr), 32'd0);
      chk("stream_beat_span", 32'(last_pop - first_pop), 32'd19999);
      chk("stream_count_le3", 32'(maxcnt <= 3), 32'd1);
    end

    // ---------------- random valid / ready with a scoreboard
    begin
      logic [15:0] sb [$];
      logic [15:0] expw;
      logic        prev_stall = 1'b0;
      logic [15:0] prev_data = '0;
      int wn = 0;
      int rn = 0;
      int rerr = 0;
      int stab_err = 0;
      do_reset;
      for (int cyc = 0; cyc < 3200; cyc++) begin
        s_valid = (cyc < 2500) ? 1'($urandom_range(0, 1)) : 1'b0;
        m_ready = (cyc < 1000) ? ~cyc[0] : 1'($urandom_range(0, 1));
        if (cyc >= 3000) m_ready = 1'b1;
        s_data  = 16'(wn * 7 + 3);
        settle;
        if (prev_stall && (!m_valid || m_data !== prev_data)) stab_err++;
        if (s_valid && s_ready) begin
          sb.push_back(s_data);
          wn++;
        end
        if (m_valid && m_ready) begin
          if (sb.size() != 0) begin
            expw = sb.pop_front();
            if (m_data !== expw) rerr++;
          end else begin
            rerr++;
          end
          rn++;
        end
        prev_stall = m_valid & ~m_ready;
        prev_data  = m_data;
        next_cycle;
      end
      chk("rand_words_written_nonzero", 32'(wn > 100), 32'd1);
      chk("rand_words_out", 32'(rn), 32'(wn));
      chk("rand_order_errors", 32'(rerr), 32'd0);
      chk("rand_stall_stability", 32'(stab_err), 32'd0);
      chk("rand_scoreboard_empty", 32'(sb.size()), 32'd0);
    end

    // ---------------- flush while a read is in flight
    begin
      int outs = 0;
      logic [15:0] first_out = '0;
      do_reset;
      s_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
        s_data = 16'h0100 + 16'(i);
        next_cycle;
      end
      s_valid = 1'b0;
      for (int i = 0; i < 4; i++) next_cycle;
      settle;
      chk("flush_pre_count", 32'(count), 32'd10);
      chk("flush_pre_head", 32'(m_data), 32'h0100);
      m_ready = 1'b1;
      settle;
      chk("flush_issue", 32'(ram_ceb), 32'd1);
      next_cycle;
      m_ready = 1'b0;
      flush = 1'b1;
      settle;
      chk("flush_s_ready", 32'(s_ready), 32'd0);
      next_cycle;
      flush = 1'b0;
      settle;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_m_valid", 32'(m_valid), 32'd0);
      s_valid = 1'b1;
      s_data  = 16'hBEEF;
      m_ready = 1'b1;
      next_cycle;
      s_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
        settle;
        if (m_valid) begin
          if (outs == 0) first_out = m_data;
          outs++;
        end
        next_cycle;
      end
      chk("flush_post_outputs", 32'(outs), 32'd1);
      chk("flush_post_data", 32'(first_out), 32'hBEEF);
    end

    // ---------------- reset in the middle of a burst
    begin
      do_reset;
      s_valid = 1'b1;
      for (int i = 0; i < 2000; i++) begin
        s_data = 16'(i);
        next_cycle;
      end
      settle;
      chk("rst_pre_count", 32'(count), 32'd2000);
      reset = 1'b1;
      settle;
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_cea", 32'(ram_cea), 32'd0);
      next_cycle;
      settle;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_almost_full", 32'(almost_full), 32'd0);
      chk("rst_ceb", 32'(ram_ceb), 32'd0);
      reset   = 1'b0;
      s_data  = 16'h5A5A;
      m_ready = 1'b1;
      settle;
      chk("rst_rel_s_ready", 32'(s_ready), 32'd1);
      chk("rst_rel_cea", 32'(ram_cea), 32'd1);
      chk("rst_rel_ada", 32'(ram_ada), 32'd0);
      next_cycle;
      s_valid = 1'b0;
      settle;
      chk("rst_rel_ceb", 32'(ram_ceb), 32'd1);
      chk("rst_rel_adb", 32'(ram_adb), 32'd0);
      chk("rst_rel_count", 32'(count), 32'd1);
      next_cycle;
      next_cycle;
      settle;
      chk("rst_rel_m_valid", 32'(m_valid), 32'd1);
      chk("rst_rel_m_data", 32'(m_data), 32'h5A5A);
      next_cycle;
      settle;
      chk("rst_rel_count_after_pop", 32'(count), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
